// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver for common-anode displays.
// The divider taps are sampled as data; every output is registered.
module seg_scan #(
    parameter logic SEG_ACTIVE_LOW = 1'b1,
    parameter logic AN_ACTIVE_LOW  = 1'b1,
    parameter logic BLANK_LEADING  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic        blink_clk,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blink_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    // Bit 0 = s1, bit 1 = s2, bit 2 = history flop s3.
    logic [2:0]  scan_sync_q;
    logic [2:0]  blink_sync_q;
    logic        scan_tick;
    logic        blink_tick;

    logic [15:0] val_q;
    logic [3:0]  dpv_q;
    logic [3:0]  bev_q;
    logic [1:0]  idx_q;
    logic        phase_q;
    logic        blank_pend_q;

    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [3:0]  an_q, an_d;

    logic [3:0]  lead_zero;
    logic [3:0]  nibble;
    logic [6:0]  seg_lit;
    logic        digit_off;

    assign scan_tick  = scan_sync_q[1] & ~scan_sync_q[2];
    assign blink_tick = blink_sync_q[1] & ~blink_sync_q[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_sync_q  <= 3'b000;
            blink_sync_q <= 3'b000;
        end else begin
            scan_sync_q  <= {scan_sync_q[1:0], scan_clk};
            blink_sync_q <= {blink_sync_q[1:0], blink_clk};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q        <= 16'h0000;
            dpv_q        <= 4'h0;
            bev_q        <= 4'h0;
            idx_q        <= 2'd0;
            phase_q      <= 1'b0;
            blank_pend_q <= 1'b0;
        end else begin
            if (load) begin
                val_q <= digits;
                dpv_q <= dp_in;
                bev_q <= blink_en;
            end
            if (scan_tick) begin
                idx_q <= idx_q + 2'd1;
            end
            if (blink_tick) begin
                phase_q <= ~phase_q;
            end
            // One dark cycle after each index change keeps the old digit from ghosting.
            blank_pend_q <= scan_tick;
        end
    end

    // Digit k counts as a leading zero when nibbles k..3 are all zero.
    assign lead_zero[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lead
            assign lead_zero[gi] = (val_q[15:4*gi] == '0);
        end
    endgenerate

    assign nibble    = val_q[4*idx_q +: 4];
    assign digit_off = blank_pend_q
                     | (phase_q & bev_q[idx_q])
                     | (BLANK_LEADING & lead_zero[idx_q]);

    always_comb begin
        seg_lit = 7'h00;
        case (nibble)
            4'h0: seg_lit = 7'h3F;
            4'h1: seg_lit = 7'h06;
            4'h2: seg_lit = 7'h5B;
            4'h3: seg_lit = 7'h4F;
            4'h4: seg_lit = 7'h66;
            4'h5: seg_lit = 7'h6D;
            4'h6: seg_lit = 7'h7D;
            4'h7: seg_lit = 7'h07;
            4'h8: seg_lit = 7'h7F;
            4'h9: seg_lit = 7'h6F;
            4'hA: seg_lit = 7'h77;
            4'hB: seg_lit = 7'h7C;
            4'hC: seg_lit = 7'h39;
            4'hD: seg_lit = 7'h5E;
            4'hE: seg_lit = 7'h79;
            4'hF: seg_lit = 7'h71;
            default: seg_lit = 7'h00;
        endcase
    end

    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (!digit_off) begin
            seg_d = seg_lit ^ {7{SEG_ACTIVE_LOW}};
            dp_d  = dpv_q[idx_q] ^ SEG_ACTIVE_LOW;
            an_d  = (4'b0001 << idx_q) ^ {4{AN_ACTIVE_LOW}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
